// File: rtl/fetch_sequencer_if.sv
// Bundles the program-memory read port and the instruction handshake to the execute stage.
// The master side belongs to the sequencer; the slave side belongs to memory and execute.
interface fetch_sequencer_if #(
    parameter int unsigned n  = 16,
    parameter int unsigned aw = 3
);
    logic          mem_status_ok;
    logic [aw-1:0] mem_addr;
    logic          mem_ready;
    logic [n-1:0]  mem_data;
    logic [n-1:0]  instr;
    logic          instr_valid;
    logic          instr_ack;
    logic          jump_en;
    logic [aw-1:0] jump_addr;

    modport master (
        output mem_status_ok,
        output mem_addr,
        input  mem_ready,
        input  mem_data,
        output instr,
        output instr_valid,
        input  instr_ack,
        input  jump_en,
        input  jump_addr
    );

    modport slave (
        input  mem_status_ok,
        input  mem_addr,
        output mem_ready,
        output mem_data,
        input  instr,
        input  instr_valid,
        output instr_ack,
        output jump_en,
        output jump_addr
    );
endinterface

// File: rtl/fetch_sequencer.sv
// Program-fetch controller: walks the PC over program memory, hands each word to the
// execute stage over valid/ack, and supports jumps, abort and a read timeout.
module fetch_sequencer #(
    parameter int unsigned n   = 16,
    parameter int unsigned m   = 8,
    parameter int unsigned aw  = 3,
    parameter int unsigned tmo = 4
) (
    input  logic          clk,
    input  logic          clear_n,
    input  logic          start,
    input  logic          abort,
    input  logic [aw-1:0] last_addr,
    output logic [aw-1:0] pc,
    output logic          busy,
    output logic          done,
    output logic          err,
    fetch_sequencer_if.master bus
);
    localparam int unsigned CW = $clog2(tmo + 1);

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StWait,
        StIssue,
        StDone,
        StErr
    } state_e;

    state_e        state_q, state_d;
    logic [aw-1:0] pc_q, pc_d;
    logic [n-1:0]  instr_q, instr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [aw-1:0] pc_inc;

    assign pc_inc = aw'((32'(pc_q) + 32'd1) % m);

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            state_q <= StIdle;
            pc_q    <= '0;
            instr_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        cnt_d   = cnt_q;
        if (abort) begin
            // pc and instr are kept so the aborted position remains observable
            state_d = StIdle;
        end else begin
            case (state_q)
                StIdle, StDone, StErr: begin
                    if (start) begin
                        pc_d    = '0;
                        state_d = StFetch;
                    end
                end
                StFetch: begin
                    cnt_d   = '0;
                    state_d = StWait;
                end
                StWait: begin
                    if (bus.mem_ready) begin
                        instr_d = bus.mem_data;
                        state_d = StIssue;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                        if (cnt_q == CW'(tmo - 1)) begin
                            state_d = StErr;
                        end
                    end
                end
                StIssue: begin
                    if (bus.instr_ack) begin
                        // A jump wins over termination at last_addr
                        if (bus.jump_en) begin
                            pc_d    = bus.jump_addr;
                            state_d = StFetch;
                        end else if (pc_q == last_addr) begin
                            state_d = StDone;
                        end else begin
                            pc_d    = pc_inc;
                            state_d = StFetch;
                        end
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    assign pc                = pc_q;
    assign bus.mem_addr      = pc_q;
    assign bus.instr         = instr_q;
    assign bus.mem_status_ok = (state_q == StFetch) || (state_q == StWait);
    assign bus.instr_valid   = (state_q == StIssue);
    assign busy              = (state_q == StFetch) || (state_q == StWait) ||
                               (state_q == StIssue);
    assign done              = (state_q == StDone);
    assign err               = (state_q == StErr);
endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Program-fetch controller for the 8-entry program memory.
- Walks the program counter from address 0 to the last loaded address and drives the memory read strobe and address.
- Captures each returned word and hands it to the execute stage over a valid/ack handshake.
- Supports jumps and abort, and flags a read timeout when the memory never reports ready.

Parameters:
- n, 16, instruction/data word width (matches program memory width)
- m, 8, program memory depth in words
- aw, 3, address width; m = 2**aw
- tmo, 4, number of WAIT cycles with mem_ready low before the error is flagged

Ports:
- clk  input  1  system clock, rising edge
- clear_n  input  1  asynchronous active-low reset
- start  input  1  level; begins a program run when sampled high in IDLE, DONE or ERR
- abort  input  1  synchronous; returns to IDLE from any state on the next edge
- last_addr  input  aw  address of the final program word (driven from the memory's load address)
- mem_status_ok  output  1  read strobe to program memory
- mem_addr  output  aw  read address to program memory
- mem_ready  input  1  memory read-ready flag
- mem_data  input  n  memory read data
- instr  output  n  captured instruction word
- instr_valid  output  1  instr holds an unconsumed word
- instr_ack  input  1  execute stage consumes instr
- jump_en  input  1  sampled only on an accepted ack; redirects the PC
- jump_addr  input  aw  jump target
- pc  output  aw  address of the current or next fetch
- busy  output  1  high in FETCH, WAIT and ISSUE
- done  output  1  run completed
- err  output  1  read timeout occurred

Behaviour:
- Reset (clear_n low, asynchronous): state=IDLE, pc=0, mem_addr=0, mem_status_ok=0, instr=0, instr_valid=0, busy=0, done=0, err=0, timeout count=0.
- mem_addr is always equal to the registered pc.
- mem_status_ok=1 only in FETCH and WAIT, so the memory is free for loading in IDLE, DONE and ERR.
- States: IDLE, FETCH, WAIT, ISSUE, DONE, ERR.
- IDLE: on start=1, set pc=0, clear done and err, go to FETCH.
- DONE: done=1. On start=1, behave as in IDLE (restart from pc=0).
- ERR: err=1. On start=1, behave as in IDLE (restart from pc=0).
- FETCH: lasts one cycle. Memory samples mem_addr on the exiting edge. Clear the timeout count. Go to WAIT.
- WAIT, mem_ready=1: instr<=mem_data, instr_valid<=1, go to ISSUE.
- WAIT, mem_ready=0: increment the timeout count. When the count reaches tmo, go to ERR with instr_valid=0.
- ISSUE: instr_valid held high and instr held stable until instr_ack=1. While ack is low the state and all outputs hold.
- ISSUE on ack, priority order:
  - if pc==last_addr and jump_en=0: go to DONE, instr_valid<=0.
  - if jump_en=1: pc<=jump_addr, go to FETCH. A jump also overrides termination.
  - otherwise: pc<=pc+1 modulo m, go to FETCH.
- Wrap-around: pc increments modulo 2**aw. If a jump lands beyond last_addr, the run continues through the wrap and terminates only at last_addr.
- Latency:
  - start edge to instr_valid high: 3 edges (IDLE->FETCH->WAIT->ISSUE).
  - Sustained throughput with ack tied high: one instruction per 3 cycles.
- Abort:
  - overrides start and ack in the same cycle.
  - next state IDLE, instr_valid=0, mem_status_ok=0.
  - pc and instr hold their values; done and err are cleared.
- Simultaneous start and abort in IDLE: abort wins, stay in IDLE.
- last_addr is sampled only on ack. Changing it mid-run is legal and takes effect at the next ack.
- Reset asserted mid-run: immediate return to reset values; any pending instr is discarded.

Test Plan:
- Memory loaded 0xA000..0xA007, last_addr=7, start pulse, ack tied high -> instr sequence 0xA000..0xA007, each valid for 1 cycle, 3 cycles apart; done=1 after the 8th ack; mem_status_ok=0 in DONE.
- Same program, ack held low for 5 cycles on word 2 -> instr=0xA002 stable with valid high for all 5 cycles; pc stays 2; no further fetch issued.
- last_addr=5; ack with jump_en=1, jump_addr=1 at pc=3 -> fetch order 0,1,2,3,1,2,3,4,5 then done.
- last_addr=2; jump to 6 -> fetch order 0,6,7,0,1,2 (wrap) then done.
- mem_ready forced 0 during WAIT -> err=1 after 4 WAIT cycles, busy=0; a new start clears err and refetches address 0.
- abort in ISSUE at pc=4 -> next cycle IDLE, instr_valid=0, pc=4. clear_n pulsed low mid-WAIT -> all outputs at reset values immediately, without waiting for a clock edge.
